// File: rtl/config_frame_loader.sv
// config_frame_loader: assembles a streamed config frame into a shadow register and commits it with a cset strobe
module config_frame_loader #(
  parameter int CONF_WIDTH = 3072,
  parameter int IN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CONF_WIDTH-1:0] c,
  output logic                  cset,
  output logic                  busy,
  output logic                  done
);
  localparam int NW = (CONF_WIDTH + IN_W - 1) / IN_W;
  localparam int CW = $clog2(NW + 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [CONF_WIDTH-1:0] shadow;
  assign c = shadow;
  // Frame FSM: bit-wise word placement drops the unused top bits of a short final word naturally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      shadow <= '0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      cset <= 1'b0;
      done <= 1'b0;
    end else begin
      cset <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state <= LOAD;
            count <= '0;
            shadow <= '0;
            in_ready <= 1'b1;
            busy <= 1'b1;
          end
        LOAD:
          if (abort) begin
            state <= IDLE;
            in_ready <= 1'b0;
            busy <= 1'b0;
          end else if (in_valid) begin
            count <= count + CW'(1);
            for (int i = 0; i < CONF_WIDTH; i++)
              if (count == CW'(i / IN_W)) shadow[i] <= in_data[i % IN_W];
            if (count == CW'(NW - 1)) begin
              state <= COMMIT;
              in_ready <= 1'b0;
              cset <= 1'b1;
            end
          end
        COMMIT: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
